// File: rtl/ency_pixel_packer.sv
// ---------------------------------------------------------------------------
// ency_pixel_packer
//
// Packs the encrypted pixel stream coming out of ency_master (one 24-bit
// pixel per cycle, bytes R,G,B) into little-endian 32-bit words and buffers
// them in a small FIFO for the memory writer. The upstream LFSRs cannot
// stall, so this block never backpressures. When the FIFO is full and
// nothing pops, the word is dropped and a sticky overflow flag is raised.
// The final word of every image is tagged with word_last.
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset
//   pix_valid   pix_data carries a valid pixel this cycle
//   pix_data    [7:0]=R, [15:8]=G, [23:16]=B
//   word_valid  FIFO head valid
//   word_ready  consumer accepts the head when word_valid && word_ready
//   word_data   packed word, first byte of the stream in [7:0]
//   word_last   head word is the final word of an image
//   img_done    1-cycle pulse when an image's final word is written
//   img_count   completed images (wraps)
//   overflow    sticky: a word was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module ency_pixel_packer #(
    parameter int FIFO_DEPTH = 8,
    parameter int IMG_PIXELS = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [31:0] word_data,
    output logic        word_last,
    output logic        img_done,
    output logic [15:0] img_count,
    output logic        overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
    localparam logic [CW-1:0] LAST_PIX = CW'(IMG_PIXELS - 1);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    // ---------------- packing state ----------------
    logic [1:0]    phase_reg, phase_next;
    logic [23:0]   res_reg, res_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          flush_reg, flush_next;   // residual of a finished image still to be written
    logic [15:0]   img_count_reg;
    logic          overflow_reg;

    logic          end_img;
    logic          wr_en;
    logic [31:0]   wr_data;
    logic          wr_last;

    always_comb begin
        phase_next = phase_reg;
        res_next   = res_reg;
        cnt_next   = cnt_reg;
        flush_next = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        wr_last    = 1'b0;
        end_img    = pix_valid && (cnt_reg == LAST_PIX);

        // The flush cycle always sees phase 0, and a phase-0 pixel never
        // produces a word, so the two sources below never collide.
        if (flush_reg) begin
            wr_en   = 1'b1;
            wr_data = {8'h00, res_reg};   // residual is already zero above its valid bytes
            wr_last = 1'b1;
        end

        if (pix_valid) begin
            case (phase_reg)
                2'd0: begin
                    res_next = pix_data;
                end
                2'd1: begin
                    wr_en    = 1'b1;
                    wr_data  = {pix_data[7:0], res_reg};
                    res_next = {8'h00, pix_data[23:8]};
                end
                2'd2: begin
                    wr_en    = 1'b1;
                    wr_data  = {pix_data[15:0], res_reg[15:0]};
                    res_next = {16'h0000, pix_data[23:16]};
                end
                default: begin
                    wr_en    = 1'b1;
                    wr_data  = {pix_data, res_reg[7:0]};
                    wr_last  = end_img;
                    res_next = '0;
                end
            endcase

            if (end_img) begin
                phase_next = 2'd0;
                cnt_next   = '0;
                flush_next = (phase_reg != 2'd3);
            end else begin
                phase_next = phase_reg + 2'd1;
                cnt_next   = cnt_reg + CW'(1);
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [32:0]   mem [FIFO_DEPTH];      // {last, data}
    logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [AW:0]   fill_reg;
    logic          fifo_empty, fifo_full, pop, push, drop;

    assign fifo_empty = (fill_reg == '0);
    assign fifo_full  = (fill_reg == FULL_LVL);
    assign pop        = !fifo_empty && word_ready;
    // A pop frees the slot in the same cycle, so a write into a full FIFO
    // is still accepted when the consumer is taking the head.
    assign push       = wr_en && (!fifo_full || pop);
    assign drop       = wr_en && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {wr_last, wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg     <= '0;
            res_reg       <= '0;
            cnt_reg       <= '0;
            flush_reg     <= 1'b0;
            img_count_reg <= '0;
            overflow_reg  <= 1'b0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            fill_reg      <= '0;
        end else begin
            phase_reg <= phase_next;
            res_reg   <= res_next;
            cnt_reg   <= cnt_next;
            flush_reg <= flush_next;
            if (wr_en && wr_last) begin
                img_count_reg <= img_count_reg + 16'd1;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   fill_reg <= fill_reg + (AW + 1)'(1);
                2'b01:   fill_reg <= fill_reg - (AW + 1)'(1);
                default: fill_reg <= fill_reg;
            endcase
        end
    end

    // Head is forced to zero while empty so the outputs read 0 after reset
    // without having to clear the storage array.
    assign word_valid = !fifo_empty;
    assign word_data  = fifo_empty ? 32'h0 : mem[rd_ptr_reg][31:0];
    assign word_last  = fifo_empty ? 1'b0  : mem[rd_ptr_reg][32];
    assign img_done   = !rst && wr_en && wr_last;
    assign img_count  = img_count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_ency_pixel_packer.sv
// ---------------------------------------------------------------------------
// Bench for ency_pixel_packer. Two instances share all inputs: instance A
// has 4-pixel images, instance B has 5-pixel images; each test checks the
// instance it targets. Inputs change 1 ns after posedge, outputs are
// sampled on negedge.
// ---------------------------------------------------------------------------
module tb_ency_pixel_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        word_ready;

    logic        a_word_valid, a_word_last, a_img_done, a_overflow;
    logic [31:0] a_word_data;
    logic [15:0] a_img_count;
    logic        b_word_valid, b_word_last, b_img_done, b_overflow;
    logic [31:0] b_word_data;
    logic [15:0] b_img_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ency_pixel_packer #(.FIFO_DEPTH(8), .IMG_PIXELS(4)) u_a (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
        .word_valid(a_word_valid), .word_ready(word_ready), .word_data(a_word_data),
        .word_last(a_word_last), .img_done(a_img_done), .img_count(a_img_count),
        .overflow(a_overflow)
    );

    ency_pixel_packer #(.FIFO_DEPTH(8), .IMG_PIXELS(5)) u_b (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
        .word_valid(b_word_valid), .word_ready(word_ready), .word_data(b_word_data),
        .word_last(b_word_last), .img_done(b_img_done), .img_count(b_img_count),
        .overflow(b_overflow)
    );

    typedef struct {
        bit          sel;    // 0 = instance A, 1 = instance B
        bit          pv;
        logic [23:0] pd;
        bit          rdy;
        bit          ev;     // expected word_valid
        logic [31:0] ed;     // expected word_data (checked when ev)
        bit          el;     // expected word_last (checked when ev)
        bit          edone;  // expected img_done
    } vec_t;

    vec_t t1[6];
    vec_t t2[9];
    vec_t t6[9];

    function automatic vec_t mk(bit sel, bit pv, logic [23:0] pd, bit rdy,
                                bit ev, logic [31:0] ed, bit el, bit edone);
        vec_t v;
        v.sel = sel; v.pv = pv; v.pd = pd; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.el = el; v.edone = edone;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pix_valid = 1'b0; pix_data = '0; word_ready = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int idx);
        logic        ov, ol, od;
        logic [31:0] odata;
        pix_valid  = v.pv;
        pix_data   = v.pd;
        word_ready = v.rdy;
        @(negedge clk);
        ov    = v.sel ? b_word_valid : a_word_valid;
        ol    = v.sel ? b_word_last  : a_word_last;
        od    = v.sel ? b_img_done   : a_img_done;
        odata = v.sel ? b_word_data  : a_word_data;
        cmp($sformatf("%s[%0d].valid", tag, idx), 32'(ov), 32'(v.ev));
        cmp($sformatf("%s[%0d].img_done", tag, idx), 32'(od), 32'(v.edone));
        if (v.ev) begin
            cmp($sformatf("%s[%0d].data", tag, idx), odata, v.ed);
            cmp($sformatf("%s[%0d].last", tag, idx), 32'(ol), 32'(v.el));
        end
        $display("%s[%0d] pv=%0b pd=%06h rdy=%0b -> valid=%0b data=%08h last=%0b done=%0b",
                 tag, idx, v.pv, v.pd, v.rdy, ov, odata, ol, od);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] seq_pix(int i);
        return {8'(3 * i + 3), 8'(3 * i + 2), 8'(3 * i + 1)};
    endfunction

    function automatic logic [31:0] seq_word(int k);
        return {8'(4 * k + 4), 8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1)};
    endfunction

    initial begin
        int          pops;
        logic [31:0] last_data;
        logic        last_flag;

        // Test 1: IMG_PIXELS=4 back-to-back
        t1[0] = mk(0, 1, 24'h030201, 1, 0, 32'h0, 0, 0);
        t1[1] = mk(0, 1, 24'h060504, 1, 0, 32'h0, 0, 0);
        t1[2] = mk(0, 1, 24'h090807, 1, 1, 32'h04030201, 0, 0);
        t1[3] = mk(0, 1, 24'h0C0B0A, 1, 1, 32'h08070605, 0, 1);
        t1[4] = mk(0, 0, 24'h000000, 1, 1, 32'h0C0B0A09, 1, 0);
        t1[5] = mk(0, 0, 24'h000000, 1, 0, 32'h0, 0, 0);
        // Test 2: IMG_PIXELS=5, flush word, pixel in flush cycle is ph0
        t2[0] = mk(1, 1, 24'h000001, 1, 0, 32'h0, 0, 0);
        t2[1] = mk(1, 1, 24'h000002, 1, 0, 32'h0, 0, 0);
        t2[2] = mk(1, 1, 24'h000003, 1, 1, 32'h02000001, 0, 0);
        t2[3] = mk(1, 1, 24'h000004, 1, 1, 32'h00030000, 0, 0);
        t2[4] = mk(1, 1, 24'h000005, 1, 1, 32'h00000400, 0, 0);
        t2[5] = mk(1, 1, 24'h000006, 1, 0, 32'h0, 0, 1);
        t2[6] = mk(1, 1, 24'h000007, 1, 1, 32'h00000005, 1, 0);
        t2[7] = mk(1, 0, 24'h000000, 1, 1, 32'h07000006, 0, 0);
        t2[8] = mk(1, 0, 24'h000000, 1, 0, 32'h0, 0, 0);
        // Test 6: pix_valid toggling
        t6[0] = mk(0, 1, 24'h030201, 1, 0, 32'h0, 0, 0);
        t6[1] = mk(0, 0, 24'h000000, 1, 0, 32'h0, 0, 0);
        t6[2] = mk(0, 1, 24'h060504, 1, 0, 32'h0, 0, 0);
        t6[3] = mk(0, 0, 24'h000000, 1, 1, 32'h04030201, 0, 0);
        t6[4] = mk(0, 1, 24'h090807, 1, 0, 32'h0, 0, 0);
        t6[5] = mk(0, 0, 24'h000000, 1, 1, 32'h08070605, 0, 0);
        t6[6] = mk(0, 1, 24'h0C0B0A, 1, 0, 32'h0, 0, 1);
        t6[7] = mk(0, 0, 24'h000000, 1, 1, 32'h0C0B0A09, 1, 0);
        t6[8] = mk(0, 0, 24'h000000, 1, 0, 32'h0, 0, 0);

        // Reset state
        do_reset();
        @(negedge clk);
        cmp("reset.valid", 32'(a_word_valid), 32'h0);
        cmp("reset.data", a_word_data, 32'h0);
        cmp("reset.last", 32'(a_word_last), 32'h0);
        cmp("reset.img_done", 32'(a_img_done), 32'h0);
        cmp("reset.img_count", 32'(a_img_count), 32'h0);
        cmp("reset.overflow", 32'(a_overflow), 32'h0);
        $display("reset: valid=%0b count=%0d overflow=%0b", a_word_valid, a_img_count, a_overflow);
        @(posedge clk); #1;

        // Test 1
        for (int i = 0; i < 6; i++) run_vec(t1[i], "t1", i);
        cmp("t1.img_count", 32'(a_img_count), 32'd1);

        // Test 2
        do_reset();
        for (int i = 0; i < 9; i++) run_vec(t2[i], "t2", i);
        cmp("t2.img_count", 32'(b_img_count), 32'd1);

        // Test 3: ready low, 12 pixels -> 9 words, 9th dropped
        do_reset();
        word_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            pix_valid = 1'b1; pix_data = seq_pix(i);
            step();
        end
        pix_valid = 1'b0;
        step();
        @(negedge clk);
        cmp("t3.full_valid", 32'(a_word_valid), 32'h1);
        cmp("t3.overflow", 32'(a_overflow), 32'h1);
        cmp("t3.img_count", 32'(a_img_count), 32'd3);
        $display("t3 stream: valid=%0b overflow=%0b count=%0d", a_word_valid, a_overflow, a_img_count);
        @(posedge clk); #1;
        word_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            cmp($sformatf("t3.drain[%0d].valid", k), 32'(a_word_valid), 32'h1);
            cmp($sformatf("t3.drain[%0d].data", k), a_word_data, seq_word(k));
            cmp($sformatf("t3.drain[%0d].last", k), 32'(a_word_last), 32'((k % 3) == 2));
            $display("t3 drain[%0d] data=%08h last=%0b", k, a_word_data, a_word_last);
            @(posedge clk); #1;
        end
        @(negedge clk);
        cmp("t3.empty", 32'(a_word_valid), 32'h0);
        @(posedge clk); #1;

        // Test 4: FIFO full (instance B), pop and ph1 write in the same cycle
        do_reset();
        word_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            pix_valid = 1'b1; pix_data = 24'(i + 1);
            step();
        end
        pix_valid = 1'b1; pix_data = 24'h00000C; word_ready = 1'b1;
        @(negedge clk);
        cmp("t4.full_valid", 32'(b_word_valid), 32'h1);
        cmp("t4.head", b_word_data, 32'h02000001);
        cmp("t4.overflow_before", 32'(b_overflow), 32'h0);
        $display("t4 full: head=%08h overflow=%0b", b_word_data, b_overflow);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pops = 0; last_data = '0; last_flag = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b_word_valid) begin
                pops++;
                last_data = b_word_data;
                last_flag = b_word_last;
            end
            @(posedge clk); #1;
        end
        cmp("t4.drain_count", 32'(pops), 32'd8);
        cmp("t4.final_word", last_data, 32'h0C00000B);
        cmp("t4.final_last", 32'(last_flag), 32'h0);
        cmp("t4.overflow_after", 32'(b_overflow), 32'h0);
        $display("t4 drain: pops=%0d final=%08h overflow=%0b", pops, last_data, b_overflow);

        // Test 5: reset mid-image
        do_reset();
        pix_valid = 1'b1; pix_data = 24'h030201; step();
        pix_data = 24'h060504; step();
        pix_valid = 1'b0; rst = 1'b1; step();
        rst = 1'b0;
        @(negedge clk);
        cmp("t5.valid", 32'(a_word_valid), 32'h0);
        cmp("t5.data", a_word_data, 32'h0);
        cmp("t5.last", 32'(a_word_last), 32'h0);
        cmp("t5.img_done", 32'(a_img_done), 32'h0);
        cmp("t5.img_count", 32'(a_img_count), 32'h0);
        cmp("t5.overflow", 32'(a_overflow), 32'h0);
        $display("t5 after rst: valid=%0b data=%08h", a_word_valid, a_word_data);
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) run_vec(t1[i], "t5", i);
        cmp("t5.img_count_end", 32'(a_img_count), 32'd1);

        // Test 6
        do_reset();
        for (int i = 0; i < 9; i++) run_vec(t6[i], "t6", i);
        cmp("t6.img_count", 32'(a_img_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
